// File: rtl/la_capture_engine.sv
// Logic-analyzer capture controller: register-bus slave plus circular pre-trigger sample-memory writer.
// Optional immediate-capture mode is compiled in when LA_CAPTURE_IMMEDIATE_MODE_EN is defined.
module la_capture_engine #(
    parameter int SAMPLE_DEPTH = 1024,
    parameter int BASE_ADDR    = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            trig_i,
    input  logic [15:0]                     addr_i,
    input  logic [15:0]                     wdata_i,
    input  logic [15:0]                     rdata_i,
    input  logic                            rw_i,
    input  logic                            valid_i,
    output logic [15:0]                     addr_o,
    output logic [15:0]                     wdata_o,
    output logic [15:0]                     rdata_o,
    output logic                            rw_o,
    output logic                            valid_o,
    output logic [$clog2(SAMPLE_DEPTH)-1:0] bram_addr_o,
    output logic                            bram_we_o
);
    localparam int AW = $clog2(SAMPLE_DEPTH);
    localparam logic [AW-1:0] LOC_MAX = AW'(SAMPLE_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MOVE     = 3'd1,
        S_IN_POS   = 3'd2,
        S_CAPTURE  = 3'd3,
        S_CAPTURED = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wp_q, wp_d, rp_q, rp_d, wp_inc_s;
    logic [AW-1:0]   loc_q, loc_sat_s;
    logic            start_q, start_prev_q, stop_q, stop_prev_q;
    logic            start_evt_s, stop_evt_s, cfg_open_s, immediate_s;
    logic [15:0]     off_s, rd_data_s;
    logic            in_range_s, wr_s, rd_s;

    assign off_s       = addr_i - 16'(BASE_ADDR);
    assign in_range_s  = (addr_i >= 16'(BASE_ADDR)) && (off_s < 16'd7);
    assign wr_s        = valid_i && rw_i && in_range_s;
    assign rd_s        = valid_i && !rw_i && in_range_s;
    assign start_evt_s = start_q && !start_prev_q;
    assign stop_evt_s  = stop_q && !stop_prev_q;
    assign cfg_open_s  = (state_q == S_IDLE) || (state_q == S_CAPTURED);
    assign wp_inc_s    = wp_q + AW'(1);

`ifdef LA_CAPTURE_IMMEDIATE_MODE_EN
    logic mode_q;

    // Trigger-mode register, only writable while no capture is in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
        end else if (wr_s && (off_s[2:0] == 3'd1) && cfg_open_s) begin
            mode_q <= wdata_i[0];
        end
    end
    assign immediate_s = mode_q;
`else
    assign immediate_s = 1'b0;
`endif

    // Saturate requested trigger position to the last buffer slot
    always_comb begin
        if ({1'b0, wdata_i} >= 17'(SAMPLE_DEPTH)) begin
            loc_sat_s = LOC_MAX;
        end else begin
            loc_sat_s = wdata_i[AW-1:0];
        end
    end

    // Register readback mux
    always_comb begin
        rd_data_s = 16'd0;
        case (off_s[2:0])
            3'd0:    rd_data_s = 16'(state_q);
            3'd1:    rd_data_s = 16'(immediate_s);
            3'd2:    rd_data_s = 16'(loc_q);
            3'd3:    rd_data_s = 16'(start_q);
            3'd4:    rd_data_s = 16'(stop_q);
            3'd5:    rd_data_s = 16'(rp_q);
            3'd6:    rd_data_s = 16'(wp_q);
            default: rd_data_s = 16'd0;
        endcase
    end

    // Bus forwarding, register writes and start/stop edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_o       <= 16'd0;
            wdata_o      <= 16'd0;
            rdata_o      <= 16'd0;
            rw_o         <= 1'b0;
            valid_o      <= 1'b0;
            loc_q        <= {AW{1'b0}};
            start_q      <= 1'b0;
            stop_q       <= 1'b0;
            start_prev_q <= 1'b0;
            stop_prev_q  <= 1'b0;
        end else begin
            addr_o       <= addr_i;
            wdata_o      <= wdata_i;
            rw_o         <= rw_i;
            valid_o      <= valid_i;
            rdata_o      <= rd_s ? rd_data_s : rdata_i;
            start_prev_q <= start_q;
            stop_prev_q  <= stop_q;
            if (wr_s) begin
                case (off_s[2:0])
                    3'd2:    if (cfg_open_s) loc_q <= loc_sat_s;
                    3'd3:    start_q <= |wdata_i;
                    3'd4:    stop_q  <= |wdata_i;
                    default: ;
                endcase
            end
        end
    end

    // FSM state and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wp_q    <= {AW{1'b0}};
            rp_q    <= {AW{1'b0}};
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
        end
    end

    // Next state; the trigger write pins read_pointer so the trigger lands at read_pointer + trigger_loc
    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        if (stop_evt_s) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_CAPTURED: begin
                    if (start_evt_s) begin
                        wp_d    = {AW{1'b0}};
                        rp_d    = {AW{1'b0}};
                        state_d = (loc_q == {AW{1'b0}}) ? S_IN_POS : S_MOVE;
                    end else begin
                        state_d = state_q;
                    end
                end
                S_MOVE: begin
                    wp_d    = wp_inc_s;
                    state_d = (wp_inc_s == loc_q) ? S_IN_POS : S_MOVE;
                end
                S_IN_POS: begin
                    wp_d = wp_inc_s;
                    if (trig_i || immediate_s) begin
                        rp_d    = wp_q - loc_q;
                        state_d = (loc_q == LOC_MAX) ? S_CAPTURED : S_CAPTURE;
                    end else begin
                        rp_d    = wp_inc_s - loc_q;
                        state_d = S_IN_POS;
                    end
                end
                S_CAPTURE: begin
                    wp_d    = wp_inc_s;
                    state_d = (wp_q == rp_q - AW'(1)) ? S_CAPTURED : S_CAPTURE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Sample-memory strobes decoded from registered state only
    always_comb begin
        bram_addr_o = wp_q;
        case (state_q)
            S_MOVE, S_IN_POS, S_CAPTURE: bram_we_o = 1'b1;
            default:                     bram_we_o = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_la_capture_engine.sv
// Self-checking bench for la_capture_engine (SAMPLE_DEPTH=8, BASE_ADDR=0) with randomized triggers.
module tb_la_capture_engine;
    localparam int D  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          trig_i = 1'b0;
    logic [15:0]   addr_i = 16'd0, wdata_i = 16'd0, rdata_i = 16'd0;
    logic          rw_i = 1'b0, valid_i = 1'b0;
    logic [15:0]   addr_o, wdata_o, rdata_o;
    logic          rw_o, valid_o;
    logic [AW-1:0] bram_addr_o;
    logic          bram_we_o;

    int checks = 0;
    int errors = 0;
    int m_loc  = 0;

    always #5 clk = ~clk;

    la_capture_engine #(.SAMPLE_DEPTH(D), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .trig_i(trig_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_i(rdata_i),
        .rw_i(rw_i), .valid_i(valid_i),
        .addr_o(addr_o), .wdata_o(wdata_o), .rdata_o(rdata_o),
        .rw_o(rw_o), .valid_o(valid_o),
        .bram_addr_o(bram_addr_o), .bram_we_o(bram_we_o)
    );

    task automatic idle_bus();
        valid_i = 1'b0; rw_i = 1'b0; addr_i = 16'd0; wdata_i = 16'd0; rdata_i = 16'd0;
    endtask

    task automatic bus_xfer(input logic [15:0] a, input logic [15:0] d, input logic rw, input logic [15:0] rd);
        addr_i = a; wdata_i = d; rw_i = rw; rdata_i = rd; valid_i = 1'b1;
        @(posedge clk); #1;
        idle_bus();
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] v);
        bus_xfer(a, 16'h0000, 1'b0, 16'($urandom));
        v = rdata_o;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            addr_i = 16'($urandom); wdata_i = 16'($urandom); rdata_i = 16'($urandom);
            rw_i = 1'($urandom); valid_i = 1'b1; trig_i = 1'b1;
            @(posedge clk); #1;
            checks++;
            if ({addr_o, wdata_o, rdata_o, rw_o, valid_o, bram_addr_o, bram_we_o} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got addr=%h wdata=%h rdata=%h rw=%b valid=%b baddr=%0d we=%b required all 0",
                         addr_o, wdata_o, rdata_o, rw_o, valid_o, bram_addr_o, bram_we_o);
            end
        end
        idle_bus(); trig_i = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            logic [15:0] a;
            a = (i == 0) ? 16'd0 : ((i == 1) ? 16'd5 : 16'd6);
            bus_read(a, v);
            checks++;
            if (v !== 16'h0000 || valid_o !== 1'b1) begin
                errors++;
                $display("FAIL reset_readback +%0d: got %h valid=%b required 0000 valid=1", a, v, valid_o);
            end
            @(posedge clk); #1;
            checks++;
            if (valid_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid_pulse +%0d: got valid=%b required 0", a, valid_o);
            end
        end
    endtask

    task automatic test_passthrough();
        logic [15:0] v, a, rd;
        bus_xfer(16'd20, 16'hBEEF, 1'b1, 16'h1234);
        checks++;
        if (addr_o !== 16'd20 || wdata_o !== 16'hBEEF || rw_o !== 1'b1 || valid_o !== 1'b1 || rdata_o !== 16'h1234) begin
            errors++;
            $display("FAIL passthrough_write: got addr=%0d wdata=%h rw=%b valid=%b rdata=%h required 20 beef 1 1 1234",
                     addr_o, wdata_o, rw_o, valid_o, rdata_o);
        end
        @(posedge clk); #1;
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL passthrough_valid_pulse: got %b required 0", valid_o);
        end
        for (int i = 0; i < 5; i++) begin
            a  = 16'($urandom_range(7, 65535));
            rd = 16'($urandom);
            bus_xfer(a, 16'($urandom), 1'b0, rd);
            checks++;
            if (rdata_o !== rd || addr_o !== a || valid_o !== 1'b1) begin
                errors++;
                $display("FAIL passthrough_read a=%h: got rdata=%h addr=%h valid=%b required %h %h 1", a, rdata_o, addr_o, valid_o, rd, a);
            end
        end
        bus_read(16'd2, v);
        checks++;
        if (v !== 16'(m_loc)) begin
            errors++;
            $display("FAIL passthrough_no_reg_change: got loc=%0d required %0d", v, m_loc);
        end
    endtask

    task automatic test_loc_saturate();
        logic [15:0] v;
        int val;
        for (int i = 0; i < 6; i++) begin
            val = (i == 0) ? 12 : $urandom_range(0, 40);
            bus_xfer(16'd2, 16'(val), 1'b1, 16'h0000);
            m_loc = (val >= D) ? D - 1 : val;
            bus_read(16'd2, v);
            checks++;
            if (v !== 16'(m_loc)) begin
                errors++;
                $display("FAIL loc_saturate wrote %0d: got %0d required %0d", val, v, m_loc);
            end
        end
    endtask

    // Expected: capture writes D+k samples at consecutive addresses from 0, k = index of trigger among IN_POSITION cycles
    task automatic run_capture(input int loc, input int kf, input bit imm, input string name);
        bit pat [0:31];
        int k, n, exp_addr;
        logic exp_we;
        logic [15:0] v;
        bus_xfer(16'd2, 16'(loc), 1'b1, 16'h0000);
        m_loc = loc;
        bus_xfer(16'd3, 16'd0, 1'b1, 16'h0000);
        for (int c = 0; c < 32; c++) pat[c] = ($urandom_range(0, 3) == 0);
        if (kf >= 0) begin
            for (int j = 0; j < kf; j++) pat[loc + 2 + j] = 1'b0;
            pat[loc + 2 + kf] = 1'b1;
        end else begin
            pat[loc + 2 + 6] = 1'b1;
        end
        k = 0;
        if (!imm) begin
            while (!pat[loc + 2 + k]) k++;
        end
        n = D + k;
        bus_xfer(16'd3, 16'd1, 1'b1, 16'h0000);
        for (int c = 1; c <= n + 1; c++) begin
            trig_i = pat[c];
            @(posedge clk); #1;
            exp_we   = (c <= n);
            exp_addr = (c - 1) % D;
            checks++;
            if (bram_we_o !== exp_we || (exp_we && bram_addr_o !== AW'(exp_addr))) begin
                errors++;
                $display("FAIL %s cycle %0d: got we=%b addr=%0d required we=%b addr=%0d",
                         name, c, bram_we_o, bram_addr_o, exp_we, exp_addr);
            end
        end
        trig_i = 1'b0;
        bus_read(16'd0, v);
        checks++;
        if (v !== 16'd4) begin errors++; $display("FAIL %s state: got %0d required 4", name, v); end
        bus_read(16'd5, v);
        checks++;
        if (v !== 16'(k % D)) begin errors++; $display("FAIL %s read_pointer: got %0d required %0d", name, v, k % D); end
        bus_read(16'd6, v);
        checks++;
        if (v !== 16'(k % D)) begin errors++; $display("FAIL %s write_pointer: got %0d required %0d", name, v, k % D); end
    endtask

    task automatic test_pretrigger();
        run_capture(3, 2, 1'b0, "pretrigger");
    endtask

    task automatic test_loc_max_direct();
        run_capture(7, 0, 1'b0, "loc_max_direct");
    endtask

    task automatic test_immediate_mode();
        logic [15:0] v;
        bus_xfer(16'd1, 16'd1, 1'b1, 16'h0000);
        bus_read(16'd1, v);
        checks++;
`ifdef LA_CAPTURE_IMMEDIATE_MODE_EN
        if (v !== 16'd1) begin errors++; $display("FAIL mode_readback: got %0d required 1", v); end
        run_capture(0, -1, 1'b1, "immediate");
        bus_xfer(16'd1, 16'd0, 1'b1, 16'h0000);
`else
        if (v !== 16'd0) begin errors++; $display("FAIL mode_absent: got %0d required 0", v); end
        run_capture(2, -1, 1'b0, "single_shot_only");
`endif
    endtask

    task automatic test_abort();
        logic [15:0] v;
        logic exp_we;
        bus_xfer(16'd4, 16'd0, 1'b1, 16'h0000);
        bus_xfer(16'd2, 16'd2, 1'b1, 16'h0000);
        m_loc = 2;
        bus_xfer(16'd3, 16'd0, 1'b1, 16'h0000);
        bus_xfer(16'd3, 16'd1, 1'b1, 16'h0000);
        for (int c = 1; c <= 8; c++) begin
            trig_i = (c == 4);
            if (c == 5) begin
                addr_i = 16'd2; wdata_i = 16'd5; rw_i = 1'b1; valid_i = 1'b1;
            end else if (c == 7) begin
                addr_i = 16'd4; wdata_i = 16'd1; rw_i = 1'b1; valid_i = 1'b1;
            end else begin
                idle_bus();
            end
            @(posedge clk); #1;
            idle_bus();
            exp_we = (c <= 7);
            checks++;
            if (bram_we_o !== exp_we || (exp_we && bram_addr_o !== AW'(c - 1))) begin
                errors++;
                $display("FAIL abort cycle %0d: got we=%b addr=%0d required we=%b addr=%0d", c, bram_we_o, bram_addr_o, exp_we, c - 1);
            end
        end
        trig_i = 1'b0;
        bus_read(16'd0, v);
        checks++;
        if (v !== 16'd0) begin errors++; $display("FAIL abort_state: got %0d required 0", v); end
        bus_read(16'd6, v);
        checks++;
        if (v !== 16'd6) begin errors++; $display("FAIL abort_write_pointer: got %0d required 6", v); end
        bus_read(16'd5, v);
        checks++;
        if (v !== 16'd0) begin errors++; $display("FAIL abort_read_pointer: got %0d required 0", v); end
        bus_read(16'd2, v);
        checks++;
        if (v !== 16'(m_loc)) begin errors++; $display("FAIL loc_write_while_capturing: got %0d required %0d", v, m_loc); end
        run_capture($urandom_range(0, 7), -1, 1'b0, "restart_after_abort");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) run_capture($urandom_range(0, 7), -1, 1'b0, "back_to_back");
    endtask

    task automatic test_async_reset();
        logic [15:0] v;
        bus_xfer(16'd2, 16'd5, 1'b1, 16'h0000);
        bus_xfer(16'd3, 16'd0, 1'b1, 16'h0000);
        bus_xfer(16'd3, 16'd1, 1'b1, 16'h0000);
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (bram_we_o !== 1'b1) begin errors++; $display("FAIL async_reset_precond: got we=%b required 1", bram_we_o); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bram_we_o, bram_addr_o, valid_o, rw_o, addr_o, wdata_o, rdata_o} !== '0) begin
            errors++;
            $display("FAIL async_reset: got we=%b addr=%0d valid=%b required all 0", bram_we_o, bram_addr_o, valid_o);
        end
        rst_n = 1'b1;
        m_loc = 0;
        @(posedge clk); #1;
        bus_read(16'd2, v);
        checks++;
        if (v !== 16'(m_loc)) begin errors++; $display("FAIL async_reset_loc: got %0d required 0", v); end
        bus_read(16'd0, v);
        checks++;
        if (v !== 16'd0) begin errors++; $display("FAIL async_reset_state: got %0d required 0", v); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_loc_saturate();
        test_pretrigger();
        test_loc_max_direct();
        test_immediate_mode();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule

// File: doc/la_capture_engine.md
# la_capture_engine

Parametrised capture controller for the logic analyzer core. It sits on the daisy-chained 16-bit register bus between the trigger block and the sample memory. It generalises the fixed single-shot controller in three ways: configurable depth, a programmable pre-trigger position (circular pre-trigger buffering), and an optional immediate-capture mode. It drives the sample memory's write address and write enable, and reports the oldest-sample pointer so the host can unroll the circular buffer.

## Interface
- `SAMPLE_DEPTH`, default 1024: number of sample-memory entries. Must be a power of two and at least 2. `AW = $clog2(SAMPLE_DEPTH)`.
- `BASE_ADDR`, default 0: first bus address of this block's 7 registers.
- `clk` input, 1 bit: the single clock.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `trig_i` input, 1 bit: trigger condition from the trigger block, sampled every cycle.
- `addr_i`, `wdata_i`, `rdata_i` input, 16 bits each: upstream bus address, write data and read data.
- `rw_i`, `valid_i` input, 1 bit each: upstream bus direction (1 = write) and strobe.
- `addr_o`, `wdata_o`, `rdata_o`, `rw_o`, `valid_o` output: downstream bus, same widths as the inputs, registered.
- `bram_addr_o` output, AW bits: sample-memory write address.
- `bram_we_o` output, 1 bit: sample-memory write enable.

## Operation
- Register map, relative to `BASE_ADDR`:
  - +0 state (RO)
  - +1 trigger_mode (RW: 0 = single-shot, 1 = immediate)
  - +2 trigger_loc (RW)
  - +3 request_start (RW)
  - +4 request_stop (RW)
  - +5 read_pointer (RO)
  - +6 write_pointer (RO)
- Bus handling:
  - A transaction is accepted when `valid_i` is high.
  - In-range write: updates an RW register. Writes to RO addresses are ignored.
  - In-range read: the register value, zero-extended, replaces `rdata_o`.
  - Out-of-range addresses pass through unchanged.
  - All bus outputs are forwarded with `valid_o` pulsed for exactly 1 cycle.
- trigger_loc:
  - Values of `SAMPLE_DEPTH` or more saturate to `SAMPLE_DEPTH-1`.
  - Writes to trigger_loc and trigger_mode are ignored unless state is IDLE or CAPTURED.
- Start and stop are edge-triggered. A 0→1 write to request_start or request_stop is the event; rewriting 1 does nothing.
- FSM state encodings: IDLE = 0, MOVE_TO_POSITION = 1, IN_POSITION = 2, CAPTURING = 3, CAPTURED = 4.
- Start event in IDLE or CAPTURED:
  - Clears write_pointer and read_pointer.
  - Moves to MOVE_TO_POSITION, or directly to IN_POSITION if trigger_loc = 0.
  - A start event in any other state is ignored.
- Writing states are MOVE_TO_POSITION, IN_POSITION and CAPTURING. In these states:
  - `bram_we_o = 1` and `bram_addr_o = write_pointer`.
  - write_pointer increments modulo `SAMPLE_DEPTH` after each write.
- MOVE_TO_POSITION: once trigger_loc samples have been written (write_pointer == trigger_loc), go to IN_POSITION. `trig_i` is ignored in this state.
- IN_POSITION:
  - Keeps writing circularly.
  - read_pointer = (write address + 1 − trigger_loc) mod depth, updated on each write.
  - In the first cycle with `trig_i` = 1 (or unconditionally in immediate mode), the sample written is the trigger sample. The FSM then goes to CAPTURING.
  - Consequence: the trigger sample sits at address read_pointer + trigger_loc.
- CAPTURING: after writing address (read_pointer − 1) mod depth, go to CAPTURED with `bram_we_o = 0`.
  - If trigger_loc = `SAMPLE_DEPTH-1`, the trigger sample is already the last sample, so IN_POSITION goes directly to CAPTURED.
  - Each capture writes exactly `SAMPLE_DEPTH` samples in total.
- Stop event, any state: go to IDLE with `bram_we_o = 0`. Both pointers hold their values. Stop takes priority over `trig_i` and over completion in the same cycle.

## Timing
- Reset values: all outputs 0, state IDLE, all registers 0, write_pointer and read_pointer 0.
- Reset asserted mid-capture aborts immediately and asynchronously to these values.
- Bus latency: outputs are valid exactly 1 cycle after `valid_i` is sampled.
- Register write timing: the register updates at the edge where `valid_i` is sampled. The FSM reacts at the following edge.
- `bram_we_o` and `bram_addr_o` are decoded from registered state and pointers only, with no combinational path from `trig_i`.

## Configuration
- `LA_CAPTURE_IMMEDIATE_MODE_EN` defined: trigger_mode is implemented as described above.
- Not defined:
  - The trigger_mode register is absent: it reads 0 and writes are ignored.
  - Operation is always single-shot.
  - No immediate-mode logic is synthesised.

## Test plan
All scenarios use `SAMPLE_DEPTH=8`, `BASE_ADDR=0`.
- Reset and readback: release reset, read +0, +5 and +6. Expect 0x0000 each with `valid_o` 1 cycle later; all outputs are 0 during reset.
- Pass-through: write addr 20, data 0xBEEF. Expect `addr_o`=20, `wdata_o`=0xBEEF, `rw_o`=1, `valid_o` high 1 cycle, and no register change.
- Pre-trigger capture: set trigger_loc=3, start, raise `trig_i` on the 3rd IN_POSITION cycle. Expect:
  - MOVE_TO_POSITION writes addresses 0, 1, 2.
  - The trigger sample lands at address 5.
  - CAPTURED is reached after writing address 1, with read_pointer=2 and write_pointer=2.
- Immediate mode, macro defined: set mode=1, trigger_loc=0, start. Expect 1 IN_POSITION cycle, then addresses 0–7 written, then CAPTURED with read_pointer=0.
- Abort: issue a stop while in CAPTURING at write_pointer=6. Expect IDLE the next cycle, `bram_we_o`=0, and pointers holding. A subsequent start restarts from address 0.
- Boundaries:
  - Write trigger_loc=12; it reads back 7.
  - With trigger_loc=7 and a trigger, IN_POSITION goes directly to CAPTURED.
  - Writing trigger_loc while CAPTURING is ignored.
